// File: rtl/ym3438_pkg.sv
// ym3438_pkg: shared constants, sample type and arithmetic helpers for the ym3438 PCM path.
package ym3438_pkg;

    localparam logic [8:0] ZERO_LEVEL = 9'h100;

    typedef struct packed {
        logic signed [15:0] l;
        logic signed [15:0] r;
    } stereo_t;

    function automatic logic signed [8:0] to_signed9(input logic [8:0] x);
        return $signed(x ^ ZERO_LEVEL);
    endfunction

    function automatic logic signed [20:0] shl21(input logic signed [14:0] x, input int unsigned sh);
        logic signed [20:0] v;
        v = 21'(x);
        return v <<< sh;
    endfunction

    function automatic logic signed [15:0] sat_shift16(input logic signed [14:0] x, input int unsigned sh);
        logic signed [20:0] v;
        v = shl21(x, sh);
        return (v > 21'sd32767) ? 16'sh7fff : (v < -21'sd32768) ? 16'sh8000 : v[15:0];
    endfunction

    function automatic logic sat_hit(input logic signed [14:0] x, input int unsigned sh);
        logic signed [15:0] q;
        q = sat_shift16(x, sh);
        return shl21(x, sh) != 21'(q);
    endfunction

endpackage

// File: rtl/ym3438_pcm_fifo.sv
// ym3438_pcm_fifo: synchronous FIFO of stereo samples; while empty the head
// output keeps showing the last popped sample.
module ym3438_pcm_fifo
    import ym3438_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic    i_clk,
    input  logic    i_rst_n,
    input  logic    i_push,
    input  stereo_t i_data,
    input  logic    i_pop,
    output logic    o_full,
    output logic    o_empty,
    output stereo_t o_data
);

    localparam int unsigned AW = $clog2(DEPTH);

    stereo_t     r_mem [DEPTH];
    stereo_t     r_last;
    logic [AW:0] r_wr;
    logic [AW:0] r_rd;
    logic        w_push;
    logic        w_pop;

    assign o_empty = r_wr == r_rd;
    assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign w_pop   = i_pop && !o_empty;
    // a pop in the same cycle frees the slot a full FIFO needs for the push
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_data  = o_empty ? r_last : r_mem[r_rd[AW-1:0]];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr   <= '0;
            r_rd   <= '0;
            r_last <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + (AW+1)'(1);
            if (w_pop) begin
                r_rd   <= r_rd + (AW+1)'(1);
                r_last <= r_mem[r_rd[AW-1:0]];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/ym3438_pcm_acc.sv
// ym3438_pcm_acc: sums each sync-framed run of MOL/MOR slots into saturated
// 16-bit stereo PCM and queues the frames for a valid/ready audio sink.
module ym3438_pcm_acc
    import ym3438_pkg::*;
#(
    parameter int unsigned FRAME_SLOTS = 24,
    parameter int unsigned SHIFT       = 2,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic               MCLK,
    input  logic               IC,
    input  logic               c1,
    input  logic               sync,
    input  logic [8:0]         MOL,
    input  logic [8:0]         MOR,
    input  logic               pcm_ready,
    input  logic               ovf_clr,
    output logic               pcm_valid,
    output logic signed [15:0] pcm_l,
    output logic signed [15:0] pcm_r,
    output logic               ovf,
    output logic               clip,
    output logic               locked
);

    localparam int unsigned CW = $clog2(FRAME_SLOTS);

    logic [CW-1:0]      r_cnt;
    logic signed [14:0] r_acc_l;
    logic signed [14:0] r_acc_r;
    logic               r_locked;
    logic               r_push;
    logic               r_ovf;
    logic               r_clip;
    stereo_t            r_res;
    stereo_t            w_head;
    logic signed [8:0]  w_sl;
    logic signed [8:0]  w_sr;
    logic signed [15:0] w_ql;
    logic signed [15:0] w_qr;
    logic               w_close;
    logic               w_sat;
    logic               w_full;
    logic               w_empty;
    logic               w_drop;

    assign w_sl    = to_signed9(MOL);
    assign w_sr    = to_signed9(MOR);
    assign w_close = c1 && r_locked && (sync || r_cnt == CW'(FRAME_SLOTS - 1));
    assign w_ql    = sat_shift16(r_acc_l, SHIFT);
    assign w_qr    = sat_shift16(r_acc_r, SHIFT);
    assign w_sat   = sat_hit(r_acc_l, SHIFT) || sat_hit(r_acc_r, SHIFT);
    assign w_drop  = r_push && w_full && !(pcm_valid && pcm_ready);

    always_ff @(posedge MCLK or negedge IC) begin
        if (!IC) begin
            r_cnt    <= '0;
            r_acc_l  <= '0;
            r_acc_r  <= '0;
            r_locked <= 1'b0;
            r_push   <= 1'b0;
            r_res    <= '0;
            r_ovf    <= 1'b0;
            r_clip   <= 1'b0;
        end else begin
            r_push <= w_close;
            r_ovf  <= w_drop || (r_ovf && !ovf_clr);
            r_clip <= (w_close && w_sat) || (r_clip && !ovf_clr);
            if (w_close) r_res <= {w_ql, w_qr};
            // the current slot starts the next frame, whether closed by sync or by count
            if (c1 && (sync || w_close)) begin
                r_locked <= 1'b1;
                r_acc_l  <= 15'(w_sl);
                r_acc_r  <= 15'(w_sr);
                r_cnt    <= '0;
            end else if (c1 && r_locked) begin
                r_acc_l <= r_acc_l + 15'(w_sl);
                r_acc_r <= r_acc_r + 15'(w_sr);
                r_cnt   <= r_cnt + CW'(1);
            end
        end
    end

    ym3438_pcm_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk   (MCLK),
        .i_rst_n (IC),
        .i_push  (r_push),
        .i_data  (r_res),
        .i_pop   (pcm_ready),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_data  (w_head)
    );

    assign pcm_valid = !w_empty;
    assign pcm_l     = w_head.l;
    assign pcm_r     = w_head.r;
    assign ovf       = r_ovf;
    assign clip      = r_clip;
    assign locked    = r_locked;

endmodule

// File: tb/tb_ym3438_pcm_acc.sv
// tb_ym3438_pcm_acc: two accumulators (SHIFT=2 and SHIFT=4) share one directed
// stimulus stream; expected frames are queued and a negedge monitor compares pops.
module tb_ym3438_pcm_acc;

    typedef struct packed {
        logic signed [15:0] l;
        logic signed [15:0] r;
    } pair_t;

    logic MCLK = 1'b0;
    logic IC, c1, sync, pcm_ready, ovf_clr;
    logic [8:0] MOL, MOR;
    logic v2, v4, o2, o4, c2, c4, k2, k4;
    logic signed [15:0] l2, r2, l4, r4;

    int n_cmp = 0;
    int n_err = 0;
    pair_t q2[$];
    pair_t q4[$];
    pair_t pend2, pend4;
    logic have_pend, pend_keep;

    always #5 MCLK = ~MCLK;

    ym3438_pcm_acc #(.FRAME_SLOTS(24), .SHIFT(2), .FIFO_DEPTH(4)) u2 (
        .MCLK(MCLK), .IC(IC), .c1(c1), .sync(sync), .MOL(MOL), .MOR(MOR),
        .pcm_ready(pcm_ready), .ovf_clr(ovf_clr), .pcm_valid(v2), .pcm_l(l2),
        .pcm_r(r2), .ovf(o2), .clip(c2), .locked(k2));

    ym3438_pcm_acc #(.FRAME_SLOTS(24), .SHIFT(4), .FIFO_DEPTH(4)) u4 (
        .MCLK(MCLK), .IC(IC), .c1(c1), .sync(sync), .MOL(MOL), .MOR(MOR),
        .pcm_ready(pcm_ready), .ovf_clr(ovf_clr), .pcm_valid(v4), .pcm_l(l4),
        .pcm_r(r4), .ovf(o4), .clip(c4), .locked(k4));

    task automatic chk(input string nm, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    always @(negedge MCLK) begin
        if (IC && pcm_ready && v2) begin
            if (q2.size() == 0) chk("u2_unexpected_entry", 1, 0);
            else begin
                pair_t e;
                e = q2.pop_front();
                chk("u2_pcm_l", l2, e.l);
                chk("u2_pcm_r", r2, e.r);
            end
        end
    end

    always @(negedge MCLK) begin
        if (IC && pcm_ready && v4) begin
            if (q4.size() == 0) chk("u4_unexpected_entry", 1, 0);
            else begin
                pair_t e;
                e = q4.pop_front();
                chk("u4_pcm_l", l4, e.l);
                chk("u4_pcm_r", r4, e.r);
            end
        end
    end

    task automatic slot(input logic [8:0] ml, input logic [8:0] mr, input logic sy,
                        input logic ck, input logic ev);
        c1 = 1'b1; sync = sy; MOL = ml; MOR = mr;
        @(posedge MCLK); #1;
        c1 = 1'b0; sync = 1'b0;
        if (ck) chk("valid_after_close_edge", v2, 0);
        @(posedge MCLK); #1;
        if (ck) chk("valid_one_mclk_later", v2, ev);
    endtask

    task automatic frame(input logic sy, input int n, input logic [8:0] ml, input logic [8:0] mr,
                         input int el2, input int er2, input int el4, input int er4, input logic keep);
        logic ev;
        ev = have_pend && pend_keep;
        if (ev) begin
            q2.push_back(pend2);
            q4.push_back(pend4);
        end
        slot(ml, mr, sy, pcm_ready, ev);
        for (int i = 1; i < n; i++) slot(ml, mr, 1'b0, 1'b0, 1'b0);
        have_pend = 1'b1;
        pend_keep = keep;
        pend2 = {16'(el2), 16'(er2)};
        pend4 = {16'(el4), 16'(er4)};
    endtask

    task automatic clr_pulse();
        ovf_clr = 1'b1;
        @(posedge MCLK); #1;
        ovf_clr = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        IC = 1'b0; c1 = 1'b0; sync = 1'b0; MOL = 9'h100; MOR = 9'h100;
        pcm_ready = 1'b1; ovf_clr = 1'b0; have_pend = 1'b0; pend_keep = 1'b0;
        pend2 = '0; pend4 = '0;
        repeat (3) @(posedge MCLK); #1;
        chk("rst_valid", v2, 0);
        chk("rst_pcm_l", l2, 0);
        chk("rst_pcm_r", r2, 0);
        chk("rst_ovf", o2, 0);
        chk("rst_clip", c2, 0);
        chk("rst_locked", k2, 0);
        chk("rst_valid_u4", v4, 0);
        IC = 1'b1;
        @(posedge MCLK); #1;

        repeat (5) slot(9'h1FF, 9'h000, 1'b0, 1'b1, 1'b0);
        chk("unlocked_before_sync", k2, 0);

        frame(1, 24, 9'h100, 9'h100, 0, 0, 0, 0, 1);
        chk("locked_after_sync", k2, 1);
        frame(1, 24, 9'h100, 9'h100, 0, 0, 0, 0, 1);
        frame(1, 24, 9'h110, 9'h0F0, 1536, -1536, 6144, -6144, 1);
        frame(1, 24, 9'h110, 9'h0F0, 1536, -1536, 6144, -6144, 1);
        frame(1, 24, 9'h1FF, 9'h000, 24480, -24576, 32767, -32768, 1);
        frame(1, 10, 9'h110, 9'h0F0, 640, -640, 2560, -2560, 1);
        chk("u2_no_clip", c2, 0);
        chk("u4_clip_set", c4, 1);
        clr_pulse();
        chk("u4_clip_cleared", c4, 0);
        frame(1, 24, 9'h101, 9'h0FF, 96, -96, 384, -384, 1);
        frame(0, 24, 9'h102, 9'h0FE, 192, -192, 768, -768, 1);
        frame(1, 24, 9'h103, 9'h0FD, 288, -288, 1152, -1152, 1);

        pcm_ready = 1'b0;
        frame(1, 24, 9'h104, 9'h0FC, 384, -384, 1536, -1536, 1);
        frame(1, 24, 9'h105, 9'h0FB, 480, -480, 1920, -1920, 1);
        frame(1, 24, 9'h106, 9'h0FA, 576, -576, 2304, -2304, 1);
        frame(1, 24, 9'h107, 9'h0F9, 672, -672, 2688, -2688, 0);
        chk("full_no_ovf", o2, 0);
        chk("full_valid", v2, 1);
        frame(1, 24, 9'h108, 9'h0F8, 768, -768, 3072, -3072, 0);
        frame(1, 24, 9'h109, 9'h0F7, 864, -864, 3456, -3456, 1);
        chk("u2_ovf_set", o2, 1);
        chk("u4_ovf_set", o4, 1);
        chk("head_stable_l", l2, 288);
        chk("head_stable_r", r2, -288);
        chk("u4_head_stable_l", l4, 1152);
        clr_pulse();
        chk("ovf_cleared", o2, 0);
        pcm_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge MCLK);
            chk("drain_valid", v2, 1);
        end
        @(negedge MCLK);
        chk("drain_empty", v2, 0);
        chk("hold_last_l", l2, 576);
        chk("hold_last_r", r2, -576);

        pcm_ready = 1'b0;
        frame(1, 24, 9'h110, 9'h0F0, 1536, -1536, 6144, -6144, 1);
        for (int i = 0; i < 12; i++) slot(9'h110, 9'h0F0, i == 0, 1'b0, 1'b0);
        chk("pre_reset_valid", v2, 1);
        #3 IC = 1'b0;
        #1;
        chk("async_rst_valid", v2, 0);
        chk("async_rst_locked", k2, 0);
        chk("async_rst_pcm_l", l2, 0);
        q2.delete();
        q4.delete();
        have_pend = 1'b0;
        @(posedge MCLK); #1;
        IC = 1'b1;
        pcm_ready = 1'b1;
        repeat (30) slot(9'h110, 9'h0F0, 1'b0, 1'b0, 1'b0);
        chk("post_rst_nothing", v2, 0);
        chk("post_rst_unlocked", k2, 0);
        frame(1, 24, 9'h110, 9'h0F0, 1536, -1536, 6144, -6144, 1);
        frame(1, 24, 9'h100, 9'h100, 0, 0, 0, 0, 1);
        repeat (10) @(posedge MCLK); #1;
        chk("u2_queue_drained", q2.size(), 0);
        chk("u4_queue_drained", q4.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
